bp_mem_io_arbiter: RTL and testbench

- Merges the core's cacheable memory command stream and its I/O command stream onto one downstream bp_mem-style command/response port.
- Lets a single memory model or endpoint serve both requesters.
- Arbitrates commands round-robin, registers the winner into a one-entry output buffer, and records the source of each accepted command in an in-order tag FIFO.
- Routes each downstream response back to the requester that issued the matching command. The downstream endpoint returns responses in command order.

---
 rtl/bp_mem_io_arbiter_pkg.sv | 13 +
 rtl/bp_mem_io_tag_fifo.sv | 60 ++++++
 rtl/bp_mem_io_arbiter.sv | 125 ++++++++++++
 tb/tb_bp_mem_io_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/bp_mem_io_arbiter_pkg.sv
// Shared types for the memory/I-O command arbiter: the source tag that travels
// through the in-order tag FIFO so responses can be steered back to their requester.
package bp_mem_io_arbiter_pkg;

    typedef enum logic {
        e_arb_src_mem = 1'b0,
        e_arb_src_io  = 1'b1
    } bp_arb_src_e;

    localparam int arb_msg_width_default_lp = 576;
    localparam int arb_tag_els_default_lp   = 4;

endpackage

// File: rtl/bp_mem_io_tag_fifo.sv
// In-order FIFO of 1-bit source tags, one entry per command accepted but not yet
// answered. The head names the requester that owns the next downstream response.
module bp_mem_io_tag_fifo
    import bp_mem_io_arbiter_pkg::*;
#(
    parameter  int tag_els_p = arb_tag_els_default_lp,
    localparam int ptr_w_lp  = $clog2(tag_els_p),
    localparam int cnt_w_lp  = $clog2(tag_els_p + 1)
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                push_v_i,
    input  bp_arb_src_e         push_data_i,
    input  logic                pop_i,
    output bp_arb_src_e         head_o,
    output logic                empty_o,
    output logic                full_o,
    output logic [cnt_w_lp-1:0] count_o
);

    bp_arb_src_e         slot_q [tag_els_p];
    logic [ptr_w_lp-1:0] rptr_q, rptr_d;
    logic [ptr_w_lp-1:0] wptr_q, wptr_d;
    logic [cnt_w_lp-1:0] count_q, count_d;
    logic                do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == cnt_w_lp'(tag_els_p));
    assign count_o = count_q;
    assign head_o  = slot_q[rptr_q];
    assign do_pop  = pop_i & ~empty_o;

    // Pointers wrap naturally because the depth is a power of two.
    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (push_v_i) wptr_d = wptr_q + ptr_w_lp'(1);
        if (do_pop)   rptr_d = rptr_q + ptr_w_lp'(1);
        if (push_v_i && !do_pop)      count_d = count_q + cnt_w_lp'(1);
        else if (!push_v_i && do_pop) count_d = count_q - cnt_w_lp'(1);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_v_i) slot_q[wptr_q] <= push_data_i;
    end

endmodule

// File: rtl/bp_mem_io_arbiter.sv
// Round-robin merge of the memory and I/O command streams onto one downstream port,
// with in-order response steering driven by the tag FIFO.
module bp_mem_io_arbiter
    import bp_mem_io_arbiter_pkg::*;
#(
    parameter int msg_width_p = arb_msg_width_default_lp,
    parameter int tag_els_p   = arb_tag_els_default_lp
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic [msg_width_p-1:0] mem_cmd_i,
    input  logic                   mem_cmd_v_i,
    output logic                   mem_cmd_ready_o,
    output logic [msg_width_p-1:0] mem_resp_o,
    output logic                   mem_resp_v_o,
    input  logic                   mem_resp_yumi_i,
    input  logic [msg_width_p-1:0] io_cmd_i,
    input  logic                   io_cmd_v_i,
    output logic                   io_cmd_ready_o,
    output logic [msg_width_p-1:0] io_resp_o,
    output logic                   io_resp_v_o,
    input  logic                   io_resp_yumi_i,
    output logic [msg_width_p-1:0] dn_cmd_o,
    output logic                   dn_cmd_v_o,
    input  logic                   dn_cmd_ready_i,
    input  logic [msg_width_p-1:0] dn_resp_i,
    input  logic                   dn_resp_v_i,
    output logic                   dn_resp_yumi_o,
    output logic                   err_o
);

    localparam int cnt_w_lp = $clog2(tag_els_p + 1);

    logic                   buf_v_q, buf_v_d;
    logic [msg_width_p-1:0] buf_q, buf_d;
    bp_arb_src_e            rr_q, rr_d;
    logic                   err_q, err_d;

    bp_arb_src_e            head;
    logic                   fifo_empty, fifo_full;
    logic [cnt_w_lp-1:0]    fifo_count;

    logic                   space, mem_gnt, io_gnt, accept;
    logic                   resp_sel_v, mem_resp_v, io_resp_v, resp_pop;

    // A pop in the same cycle does not free a slot: the count is the pre-update value.
    always_comb begin
        space   = (~buf_v_q | dn_cmd_ready_i) & (fifo_count < cnt_w_lp'(tag_els_p));
        mem_gnt = space & mem_cmd_v_i & (~io_cmd_v_i  | (rr_q == e_arb_src_mem));
        io_gnt  = space & io_cmd_v_i  & (~mem_cmd_v_i | (rr_q == e_arb_src_io));
        accept  = mem_gnt | io_gnt;
    end

    always_comb begin
        resp_sel_v = dn_resp_v_i & ~fifo_empty;
        mem_resp_v = resp_sel_v & (head == e_arb_src_mem);
        io_resp_v  = resp_sel_v & (head == e_arb_src_io);
        resp_pop   = (mem_resp_v & mem_resp_yumi_i) | (io_resp_v & io_resp_yumi_i);
    end

    always_comb begin
        buf_v_d = buf_v_q;
        buf_d   = buf_q;
        rr_d    = rr_q;
        err_d   = err_q;
        if (accept) begin
            buf_v_d = 1'b1;
            buf_d   = io_gnt ? io_cmd_i : mem_cmd_i;
            rr_d    = io_gnt ? e_arb_src_mem : e_arb_src_io;
        end else if (dn_cmd_ready_i) begin
            buf_v_d = 1'b0;
        end
        if (dn_resp_v_i && fifo_empty) err_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            buf_v_q <= 1'b0;
            rr_q    <= e_arb_src_mem;
            err_q   <= 1'b0;
        end else begin
            buf_v_q <= buf_v_d;
            rr_q    <= rr_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        buf_q <= buf_d;
    end

    bp_mem_io_tag_fifo #(
        .tag_els_p (tag_els_p)
    ) tag_fifo (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .push_v_i    (accept),
        .push_data_i (io_gnt ? e_arb_src_io : e_arb_src_mem),
        .pop_i       (resp_pop),
        .head_o      (head),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full),
        .count_o     (fifo_count)
    );

    // Gating with reset keeps every handshake output low while reset is held.
    assign mem_cmd_ready_o = reset_n_i & mem_gnt;
    assign io_cmd_ready_o  = reset_n_i & io_gnt;
    assign dn_cmd_v_o      = buf_v_q;
    assign dn_cmd_o        = buf_q;
    assign mem_resp_o      = dn_resp_i;
    assign io_resp_o       = dn_resp_i;
    assign mem_resp_v_o    = reset_n_i & mem_resp_v;
    assign io_resp_v_o     = reset_n_i & io_resp_v;
    assign dn_resp_yumi_o  = reset_n_i & resp_pop;
    assign err_o           = err_q;

`ifndef SYNTHESIS
    assert property (@(posedge clk_i) disable iff (!reset_n_i) !(dn_resp_v_i && fifo_empty))
        else $warning("bp_mem_io_arbiter: downstream response with no outstanding command");
    assert property (@(posedge clk_i) disable iff (!reset_n_i) !(accept && fifo_full))
        else $error("bp_mem_io_arbiter: tag fifo overflow");
`endif

endmodule

// File: tb/tb_bp_mem_io_arbiter.sv
// Randomized bench: queue-based reference of the merge, a latency-2 in-order downstream
// endpoint, and a negedge monitor that pops expectations as the DUT presents outputs.
module tb_bp_mem_io_arbiter;

    localparam int MW = 576;
    localparam int TE = 4;

    logic          clk_i = 1'b0;
    logic          reset_n_i = 1'b0;
    logic [MW-1:0] mem_cmd_i, io_cmd_i, dn_resp_i;
    logic [MW-1:0] mem_resp_o, io_resp_o, dn_cmd_o;
    logic          mem_cmd_v_i, mem_cmd_ready_o, mem_resp_v_o, mem_resp_yumi_i;
    logic          io_cmd_v_i, io_cmd_ready_o, io_resp_v_o, io_resp_yumi_i;
    logic          dn_cmd_v_o, dn_cmd_ready_i, dn_resp_v_i, dn_resp_yumi_o, err_o;

    bp_mem_io_arbiter #(.msg_width_p(MW), .tag_els_p(TE)) dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .mem_cmd_i       (mem_cmd_i),
        .mem_cmd_v_i     (mem_cmd_v_i),
        .mem_cmd_ready_o (mem_cmd_ready_o),
        .mem_resp_o      (mem_resp_o),
        .mem_resp_v_o    (mem_resp_v_o),
        .mem_resp_yumi_i (mem_resp_yumi_i),
        .io_cmd_i        (io_cmd_i),
        .io_cmd_v_i      (io_cmd_v_i),
        .io_cmd_ready_o  (io_cmd_ready_o),
        .io_resp_o       (io_resp_o),
        .io_resp_v_o     (io_resp_v_o),
        .io_resp_yumi_i  (io_resp_yumi_i),
        .dn_cmd_o        (dn_cmd_o),
        .dn_cmd_v_o      (dn_cmd_v_o),
        .dn_cmd_ready_i  (dn_cmd_ready_i),
        .dn_resp_i       (dn_resp_i),
        .dn_resp_v_i     (dn_resp_v_i),
        .dn_resp_yumi_o  (dn_resp_yumi_o),
        .err_o           (err_o)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;

    // Reference state: commands awaiting the downstream port, the endpoint's accepted
    // commands (response = inverted command), and the owner of each outstanding command.
    logic [MW-1:0] cmd_q [$];
    logic [MW-1:0] ep_q  [$];
    int            ep_t  [$];
    bit            src_q [$];
    int            buffered, outstanding, cyc, nresp;
    bit            rr, err_exp, mon_en, force_rv;
    int            p_mv, p_iv, p_rdy, p_yumi, p_rv;

    task automatic chk1(string name, logic act, logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s t=%0t actual=%0b required=%0b", name, $time, act, exp);
        end
    endtask

    task automatic chkm(string name, logic [MW-1:0] act, logic [MW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    function automatic logic [MW-1:0] rand_msg();
        logic [MW-1:0] m;
        for (int i = 0; i < MW / 32; i++) m[i*32 +: 32] = $urandom();
        return m;
    endfunction

    task automatic reset_model();
        cmd_q.delete(); ep_q.delete(); ep_t.delete(); src_q.delete();
        buffered = 0; outstanding = 0; rr = 1'b0; err_exp = 1'b0;
    endtask

    task automatic check_idle_outputs(string tag);
        chk1({tag, "_mem_ready"}, mem_cmd_ready_o, 1'b0);
        chk1({tag, "_io_ready"},  io_cmd_ready_o,  1'b0);
        chk1({tag, "_dn_cmd_v"},  dn_cmd_v_o,      1'b0);
        chk1({tag, "_mem_resp_v"}, mem_resp_v_o,   1'b0);
        chk1({tag, "_io_resp_v"}, io_resp_v_o,     1'b0);
        chk1({tag, "_dn_yumi"},   dn_resp_yumi_o,  1'b0);
        chk1({tag, "_err"},       err_o,           1'b0);
    endtask

    task automatic drive_cycle();
        mem_cmd_v_i     = ($urandom_range(0, 99) < p_mv);
        io_cmd_v_i      = ($urandom_range(0, 99) < p_iv);
        mem_cmd_i       = rand_msg();
        io_cmd_i        = rand_msg();
        dn_cmd_ready_i  = ($urandom_range(0, 99) < p_rdy);
        mem_resp_yumi_i = ($urandom_range(0, 99) < p_yumi);
        io_resp_yumi_i  = ($urandom_range(0, 99) < p_yumi);
        if (force_rv) begin
            dn_resp_v_i = 1'b1;
            dn_resp_i   = rand_msg();
        end else if (ep_q.size() > 0 && ep_t[0] <= cyc && $urandom_range(0, 99) < p_rv) begin
            dn_resp_v_i = 1'b1;
            dn_resp_i   = ~ep_q[0];
        end else begin
            dn_resp_v_i = 1'b0;
            dn_resp_i   = rand_msg();
        end
    endtask

    task automatic run(int n);
        repeat (n) begin
            @(posedge clk_i);
            #1 drive_cycle();
        end
    endtask

    task automatic monitor_cycle();
        bit space, mg, ig, dfire, pop, dest, y;
        // A grant needs a free buffer slot (or one draining now) and fewer than TE tags.
        space = (buffered == 0 || dn_cmd_ready_i) && (outstanding < TE);
        mg = space && mem_cmd_v_i && (!io_cmd_v_i || rr == 1'b0);
        ig = space && io_cmd_v_i && (!mem_cmd_v_i || rr == 1'b1);
        chk1("mem_ready", mem_cmd_ready_o, mg);
        chk1("io_ready",  io_cmd_ready_o,  ig);
        chk1("dn_cmd_v",  dn_cmd_v_o, buffered != 0);
        chk1("err",       err_o, err_exp);

        dfire = (buffered != 0) && dn_cmd_ready_i;
        if (dfire && cmd_q.size() > 0) begin
            chkm("dn_cmd_data", dn_cmd_o, cmd_q[0]);
            ep_q.push_back(cmd_q.pop_front());
            ep_t.push_back(cyc + 2);
        end

        pop = 1'b0;
        if (dn_resp_v_i && src_q.size() == 0) begin
            chk1("spurious_mem_resp_v", mem_resp_v_o, 1'b0);
            chk1("spurious_io_resp_v",  io_resp_v_o,  1'b0);
            chk1("spurious_dn_yumi",    dn_resp_yumi_o, 1'b0);
            err_exp = 1'b1;
        end else if (dn_resp_v_i && ep_q.size() > 0) begin
            dest = src_q[0];
            y = dest ? io_resp_yumi_i : mem_resp_yumi_i;
            chk1("mem_resp_v", mem_resp_v_o, dest == 1'b0);
            chk1("io_resp_v",  io_resp_v_o,  dest == 1'b1);
            chkm(dest ? "io_resp_data" : "mem_resp_data", dest ? io_resp_o : mem_resp_o, ~ep_q[0]);
            chk1("dn_resp_yumi", dn_resp_yumi_o, y);
            if (y) begin
                pop = 1'b1;
                void'(src_q.pop_front());
                void'(ep_q.pop_front());
                void'(ep_t.pop_front());
                nresp++;
                $display("[TB] response %0d delivered to %s", nresp, dest ? "io" : "mem");
            end
        end else begin
            chk1("idle_mem_resp_v", mem_resp_v_o, 1'b0);
            chk1("idle_io_resp_v",  io_resp_v_o,  1'b0);
            chk1("idle_dn_yumi",    dn_resp_yumi_o, 1'b0);
        end

        if (mg || ig) begin
            cmd_q.push_back(mg ? mem_cmd_i : io_cmd_i);
            src_q.push_back(ig);
            rr = mg;
        end
        buffered    = buffered + int'(mg || ig) - int'(dfire);
        outstanding = outstanding + int'(mg || ig) - int'(pop);
        cyc++;
    endtask

    always @(negedge clk_i) begin
        if (reset_n_i && mon_en) monitor_cycle();
    end

    task automatic drain(string tag);
        p_mv = 0; p_iv = 0; p_rdy = 100; p_yumi = 100; p_rv = 100;
        for (int i = 0; i < 300 && outstanding > 0; i++) run(1);
        run(1);
        tests++;
        if (outstanding != 0) begin
            fails++;
            $display("FAIL %s_timeout actual=%0d outstanding required=0", tag, outstanding);
        end
    endtask

    initial begin
        cyc = 0; nresp = 0; mon_en = 1'b0; force_rv = 1'b0;
        reset_model();
        mem_cmd_i = '0; io_cmd_i = '0; dn_resp_i = '0;
        mem_cmd_v_i = 1'b1; io_cmd_v_i = 1'b1; dn_cmd_ready_i = 1'b1;
        dn_resp_v_i = 1'b0; mem_resp_yumi_i = 1'b1; io_resp_yumi_i = 1'b1;

        repeat (3) @(posedge clk_i);
        #1 check_idle_outputs("in_reset");
        #2 reset_n_i = 1'b1;
        mon_en = 1'b1;
        @(negedge clk_i);
        chk1("first_grant_mem", mem_cmd_ready_o, 1'b1);
        chk1("first_grant_not_io", io_cmd_ready_o, 1'b0);

        p_mv = 60; p_iv = 60; p_rdy = 80; p_yumi = 80; p_rv = 80;
        run(400);
        p_mv = 100; p_iv = 100; p_rdy = 100; p_yumi = 100; p_rv = 100;
        run(60);
        p_mv = 70; p_iv = 70; p_rdy = 15; p_yumi = 30; p_rv = 50;
        run(400);
        drain("drain1");

        force_rv = 1'b1;
        run(3);
        force_rv = 1'b0;
        run(3);

        p_mv = 100; p_iv = 100; p_rdy = 100; p_yumi = 0; p_rv = 0;
        run(4);
        @(posedge clk_i);
        #3 mon_en = 1'b0;
        reset_n_i = 1'b0;
        #1 check_idle_outputs("async_reset");
        @(posedge clk_i);
        #3 reset_n_i = 1'b1;
        reset_model();
        mon_en = 1'b1;
        @(negedge clk_i);
        chk1("post_reset_grant_mem", mem_cmd_ready_o, 1'b1);
        chk1("post_reset_not_io", io_cmd_ready_o, 1'b0);

        p_mv = 50; p_iv = 80; p_rdy = 60; p_yumi = 60; p_rv = 70;
        run(200);
        drain("drain2");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
